// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing generator (hsync, vsync, data
// enable, pixel coordinates, line/frame start pulses).
// The raster stays idle until the PLL lock flag, after a 2-flop
// synchronizer, reads high. It restarts from (0,0) after any loss of lock.
// Optional feature macro: VGA_TEST_PATTERN_EN adds a 24-bit rgb output that
// carries an eight-bar colour test pattern aligned with de.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = 11
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             pll_locked,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             line_start,
    output logic             frame_start
`ifdef VGA_TEST_PATTERN_EN
    ,
    output logic [23:0]      rgb
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef enum logic {
        WAIT_LOCK = 1'b0,
        RUN       = 1'b1
    } state_t;

    state_t           state_reg;
    logic             lock_meta_reg;
    logic             lock_sync_reg;
    logic [CNT_W-1:0] h_cnt_reg;
    logic [CNT_W-1:0] v_cnt_reg;

    // Bring the asynchronous PLL lock flag into the refclk domain.
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            lock_meta_reg <= 1'b0;
            lock_sync_reg <= 1'b0;
        end else begin
            lock_meta_reg <= pll_locked;
            lock_sync_reg <= lock_meta_reg;
        end
    end

    // Lock FSM with the raster counters; losing lock clears the counters at once.
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            state_reg <= WAIT_LOCK;
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else begin
            case (state_reg)
                WAIT_LOCK: begin
                    h_cnt_reg <= '0;
                    v_cnt_reg <= '0;
                    if (lock_sync_reg) begin
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (!lock_sync_reg) begin
                        state_reg <= WAIT_LOCK;
                        h_cnt_reg <= '0;
                        v_cnt_reg <= '0;
                    end else if (h_cnt_reg == H_LAST) begin
                        h_cnt_reg <= '0;
                        v_cnt_reg <= (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 1'b1;
                    end else begin
                        h_cnt_reg <= h_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= WAIT_LOCK;
                    h_cnt_reg <= '0;
                    v_cnt_reg <= '0;
                end
            endcase
        end
    end

    // The edge that leaves RUN already drives idle outputs, so lock loss
    // blanks the display as early as possible.
    logic running;
    logic hs_window;
    logic vs_window;
    logic de_window;

    // Raster decode of the current counter position.
    always_comb begin
        running   = (state_reg == RUN) && lock_sync_reg;
        hs_window = (h_cnt_reg >= HS_FIRST) && (h_cnt_reg <= HS_LAST);
        vs_window = (v_cnt_reg >= VS_FIRST) && (v_cnt_reg <= VS_LAST);
        de_window = (h_cnt_reg < H_ACT_END) && (v_cnt_reg < V_ACT_END);
    end

    // Registered timing outputs, one cycle behind the counters.
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            de          <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (running) begin
            hsync       <= hs_window ? HS_POL : ~HS_POL;
            vsync       <= vs_window ? VS_POL : ~VS_POL;
            de          <= de_window;
            pix_x       <= h_cnt_reg;
            pix_y       <= v_cnt_reg;
            line_start  <= (h_cnt_reg == '0);
            frame_start <= (h_cnt_reg == '0) && (v_cnt_reg == '0);
        end else begin
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            de          <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [CNT_W-1:0] BAR_W = CNT_W'(H_ACTIVE / 8);

    logic [2:0]  bar_sel;
    logic [23:0] bar_colour;

    // Colour of the vertical bar under the current horizontal position.
    always_comb begin
        bar_sel = 3'(h_cnt_reg / BAR_W);
        case (bar_sel)
            3'd0:    bar_colour = 24'hFFFFFF;
            3'd1:    bar_colour = 24'hFFFF00;
            3'd2:    bar_colour = 24'h00FFFF;
            3'd3:    bar_colour = 24'h00FF00;
            3'd4:    bar_colour = 24'hFF00FF;
            3'd5:    bar_colour = 24'hFF0000;
            3'd6:    bar_colour = 24'h0000FF;
            default: bar_colour = 24'h000000;
        endcase
    end

    // Pattern pixel register, aligned with de and black outside active video.
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            rgb <= '0;
        end else if (running && de_window) begin
            rgb <= bar_colour;
        end else begin
            rgb <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a reduced raster (32x19 totals) so that
// whole frames fit in a short run. An arithmetic model derives the expected
// outputs from the edge count since lock; directed checks pin literal values.
module tb_vga_timing_gen;

    localparam int HA = 16, HF = 4, HSW = 6, HB = 6;
    localparam int VA = 12, VF = 2, VSW = 2, VB = 3;
    localparam int CW = 11;
    localparam int HT = HA + HF + HSW + HB;   // 32
    localparam int VT = VA + VF + VSW + VB;   // 19
    localparam int FRAME = HT * VT;           // 608
    localparam int NEVER = 1 << 30;

    logic          refclk = 1'b0;
    logic          rst = 1'b1;
    logic          pll_locked = 1'b1;
    logic          hsync, vsync, de, line_start, frame_start;
    logic [CW-1:0] pix_x, pix_y;
`ifdef VGA_TEST_PATTERN_EN
    logic [23:0]   rgb;
`endif

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(CW)
    ) dut (
        .refclk(refclk),
        .rst(rst),
        .pll_locked(pll_locked),
        .hsync(hsync),
        .vsync(vsync),
        .de(de),
        .pix_x(pix_x),
        .pix_y(pix_y),
        .line_start(line_start),
        .frame_start(frame_start)
`ifdef VGA_TEST_PATTERN_EN
        ,
        .rgb(rgb)
`endif
    );

    always #5 refclk = ~refclk;

    int edge_n = 0;
    always @(posedge refclk) edge_n++;

    int checks = 0;
    int failures = 0;
    // Edge after which frame_start is expected, and first edge with idle outputs.
    int run_start = -1;
    int run_end = NEVER;

    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          de;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          ls;
        logic          fs;
        logic [23:0]   rgb;
    } vo_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic logic [23:0] bar_colour(int idx);
        case (idx)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // Expected outputs after edge e: position p = e - run_start inside the raster.
    function automatic vo_t model(int e, logic rst_v);
        vo_t m;
        int p, h, v;
        m = '{hs: 1'b1, vs: 1'b1, de: 1'b0, x: '0, y: '0, ls: 1'b0, fs: 1'b0, rgb: '0};
        if (rst_v && run_start >= 0 && e >= run_start && e < run_end) begin
            p = e - run_start;
            h = p % HT;
            v = (p / HT) % VT;
            m.hs = !(h >= HA + HF && h < HA + HF + HSW);
            m.vs = !(v >= VA + VF && v < VA + VF + VSW);
            m.de = (h < HA) && (v < VA);
            m.x = CW'(h);
            m.y = CW'(v);
            m.ls = (h == 0);
            m.fs = (h == 0) && (v == 0);
            m.rgb = m.de ? bar_colour(h / (HA / 8)) : 24'h0;
        end
        return m;
    endfunction

    // Every-cycle comparison of all outputs against the model.
    always @(negedge refclk) begin : cmp
        vo_t exp_v;
        vo_t act_v;
        exp_v = model(edge_n, rst);
        act_v = '{hs: hsync, vs: vsync, de: de, x: pix_x, y: pix_y,
                  ls: line_start, fs: frame_start, rgb: '0};
`ifdef VGA_TEST_PATTERN_EN
        act_v.rgb = rgb;
`else
        exp_v.rgb = '0;
`endif
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL cycle_model edge=%0d got %h expected %h", edge_n, act_v, exp_v);
        end
    end

    // Waits for frame_start and checks it follows edge e0 by exactly 4 edges.
    task automatic wait_fs(input int e0, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge refclk);
            if (frame_start === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        if (found) check(name, 64'(edge_n - e0), 64'd4);
        else check({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    // Waits until the outputs show pixel (x, y); y < 0 matches any line.
    task automatic wait_xy(input int x, input int y, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge refclk);
            if (pix_x == CW'(x) && (y < 0 || pix_y == CW'(y)) && de === 1'b1 || (x >= HA && pix_x == CW'(x))) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) check({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic check_idle(input string name);
        check({name, "_hsync"}, 64'(hsync), 64'd1);
        check({name, "_vsync"}, 64'(vsync), 64'd1);
        check({name, "_de"}, 64'(de), 64'd0);
        check({name, "_pix_x"}, 64'(pix_x), 64'd0);
        check({name, "_pix_y"}, 64'(pix_y), 64'd0);
        check({name, "_pulses"}, 64'({line_start, frame_start}), 64'd0);
`ifdef VGA_TEST_PATTERN_EN
        check({name, "_rgb"}, 64'(rgb), 64'd0);
`endif
    endtask

    initial begin
        int e0;
        int last_fs, last_ls, de_run, hs_run, vs_run, de_lines;
        logic [CW-1:0] prev_y;

        // Reset held with the PLL already locked: everything idle.
        #1 rst = 1'b0;
        repeat (4) @(negedge refclk);
        check_idle("reset");

        // Release reset; frame_start follows 4 edges later, one cycle wide.
        @(posedge refclk);
        #1;
        rst = 1'b1;
        e0 = edge_n;
        run_start = e0 + 4;
        run_end = NEVER;
        wait_fs(e0, "lockup_latency");

        // Two full frames of period, width and offset measurements.
        last_fs = -1; last_ls = -1; de_run = 0; hs_run = 0; vs_run = 0; de_lines = 0;
        prev_y = '0;
        for (int i = 0; i <= 2 * FRAME; i++) begin
            if (i > 0) @(negedge refclk);
            if (i == 1) check("fs_width", 64'(frame_start), 64'd0);
            if (frame_start) begin
                if (last_fs >= 0) begin
                    check("fs_period", 64'(edge_n - last_fs), 64'd608);
                    check("y_wrap_from", 64'(prev_y), 64'd18);
                    check("de_lines", 64'(de_lines), 64'd12);
                end
                check("fs_y_zero", 64'(pix_y), 64'd0);
                de_lines = 0;
                last_fs = edge_n;
            end
            if (line_start) begin
                if (last_ls >= 0) check("ls_period", 64'(edge_n - last_ls), 64'd32);
                last_ls = edge_n;
            end
            if (de) de_run++;
            else if (de_run > 0) begin
                check("de_run", 64'(de_run), 64'd16);
                de_lines++;
                de_run = 0;
            end
            if (!hsync) begin
                if (hs_run == 0) check("hs_offset", 64'(edge_n - last_ls), 64'd20);
                hs_run++;
            end else if (hs_run > 0) begin
                check("hs_width", 64'(hs_run), 64'd6);
                hs_run = 0;
            end
            if (!vsync) begin
                if (vs_run == 0) begin
                    check("vs_start_line", 64'(pix_y), 64'd14);
                    check("vs_start_ls", 64'(line_start), 64'd1);
                end
                vs_run++;
            end else if (vs_run > 0) begin
                check("vs_width", 64'(vs_run), 64'd64);
                vs_run = 0;
            end
            prev_y = pix_y;
        end

`ifdef VGA_TEST_PATTERN_EN
        // Test pattern at bar boundaries and in blanking.
        wait_xy(0, 3, "pat0");
        check("rgb_x0", 64'(rgb), 64'hFFFFFF);
        wait_xy(2, 3, "pat2");
        check("rgb_x2", 64'(rgb), 64'hFFFF00);
        wait_xy(15, 3, "pat15");
        check("rgb_x15", 64'(rgb), 64'h000000);
        wait_xy(20, -1, "pat_blank");
        check("rgb_blank", 64'(rgb), 64'h0);
`endif

        // Lock loss mid-frame: idle within 3 cycles, then a clean relock.
        wait_xy(10, 5, "drop_point");
        #1;
        pll_locked = 1'b0;
        e0 = edge_n;
        run_end = e0 + 3;
        repeat (3) @(negedge refclk);
        check_idle("lock_drop");
        repeat (5) @(negedge refclk);
        #1;
        pll_locked = 1'b1;
        e0 = edge_n;
        run_start = e0 + 4;
        run_end = NEVER;
        wait_fs(e0, "relock_latency");
        repeat (FRAME + 4) @(negedge refclk);
        check("relock_next_fs", 64'(frame_start), 64'd0);

        // Asynchronous reset mid-line: idle before the next rising edge.
        wait_xy(5, -1, "rst_point");
        #1;
        rst = 1'b0;
        run_start = -1;
        #1;
        check_idle("async_rst");
        repeat (3) @(negedge refclk);
        #1;
        rst = 1'b1;
        e0 = edge_n;
        run_start = e0 + 4;
        run_end = NEVER;
        wait_fs(e0, "rst_restart_latency");
        repeat (2 * HT) @(negedge refclk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator for 640x480@60 VGA output.
- Clocked by the ~25.1 MHz pixel clock from the PLL output; consumes the PLL lock indication.
- Produces hsync/vsync, data-enable and pixel coordinates for the downstream pixel/colour stage.
- Holds the raster idle until the PLL is locked; restarts cleanly on lock loss.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level (0 = active-low)
CNT_W, 11, width of counters and coordinate outputs

Ports:
refclk  input  1  pixel clock, driven by PLL outclk_0; all logic on rising edge
rst  input  1  asynchronous, active-low reset
pll_locked  input  1  PLL lock flag, asynchronous to refclk
hsync  output  1  horizontal sync, polarity per HS_POL
vsync  output  1  vertical sync, polarity per VS_POL
de  output  1  active-video data enable
pix_x  output  CNT_W  horizontal counter value
pix_y  output  CNT_W  vertical counter value
line_start  output  1  one-cycle pulse at h=0
frame_start  output  1  one-cycle pulse at h=0, v=0

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- pll_locked passes through a 2-flop synchronizer (reset to 0) before use.
- FSM states:
  - WAIT_LOCK (reset state): h_cnt=v_cnt=0, outputs at idle.
  - WAIT_LOCK -> RUN when the synced lock is 1.
  - RUN -> WAIT_LOCK when the synced lock is 0; counters clear to 0 on the same edge. No partial-frame completion.
- Counters in RUN:
  - h_cnt increments each cycle; at H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps to 0 when h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1.
- All outputs are registered and reflect counter state (h,v) one cycle later.
- Output decode, RUN only:
  - hsync active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751).
  - vsync active for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491), for whole lines starting at h=0.
  - de = (h<H_ACTIVE) && (v<V_ACTIVE).
  - pix_x=h, pix_y=v at all times.
  - line_start = (h==0); frame_start = (h==0 && v==0).
- Idle / reset values:
  - hsync = ~HS_POL, vsync = ~VS_POL (1 by default).
  - de=0, pix_x=0, pix_y=0, line_start=0, frame_start=0.
- Reset assertion forces idle values immediately, with no clock edge required, and forces WAIT_LOCK.
- Lock-up latency: with pll_locked high, counting edges from the first edge that samples it high as edge 1, frame_start is first high after edge 4.
- Lock glitch shorter than one refclk period: may be missed. Any deassertion seen by the synchronizer forces WAIT_LOCK.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined:
  - Extra output rgb, 24 bits ({R[7:0],G[7:0],B[7:0]}), registered and aligned with de.
  - Eight vertical bars, each H_ACTIVE/8 (80) pixels wide, left to right: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - rgb=0 whenever de=0; reset value 0.
- Undefined: rgb port and pattern logic are absent; all other behaviour is identical.

Test Plan:
1. rst low with pll_locked=1 -> all outputs at idle values (hsync=1, vsync=1, de=0, coords 0). Release rst -> frame_start first high after edge 4, then exactly 1 cycle wide.
2. Run 2 frames -> 420000 cycles between frame_start pulses, 800 cycles between line_start pulses. de high for 640 consecutive cycles per line on 480 lines. hsync low 96 cycles, starting 656 cycles after line_start.
3. Vertical sync -> vsync low for exactly 1600 cycles, starting with line_start of line 490. pix_y wraps 524 -> 0 together with frame_start.
4. Drop pll_locked at (h=300, v=200) -> within 3 cycles de=0, hsync=1, vsync=1, pix_x=pix_y=0. Reassert -> frame_start after edge 4 and a full frame follows.
5. Assert rst asynchronously mid-line at h=100 -> outputs go idle before the next refclk edge. Release -> same restart sequence as scenario 1.
6. With VGA_TEST_PATTERN_EN -> rgb=FFFFFF at pix_x=0, FFFF00 at pix_x=80, 000000 at pix_x=639, 0 during blanking and in reset.
